// File: rtl/instr_feeder.sv
// Byte-pair instruction assembler feeding a small FIFO that dispatches its head
// to compute unit 0 or 1 according to instruction bit 15.
module instr_feeder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic [15:0]   instr_out,
    output logic          out_valid_0,
    input  logic          out_ready_0,
    output logic          out_valid_1,
    input  logic          out_ready_1,
    output logic [CW-1:0] fifo_count,
    output logic          hi_pending,
    output logic          overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      hi_reg;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [15:0]     head;
    logic            full;
    logic            empty;
    logic            byte_acc;
    logic            push;
    logic            pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == CW'(0));
    assign head  = mem[rd_ptr];

    // Assembler state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_HI;
        end else begin
            state <= state_nxt;
        end
    end

    // Assembler next-state logic; flush wins over any byte acceptance
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = WAIT_HI;
        end else begin
            case (state)
                WAIT_HI: if (byte_valid) state_nxt = WAIT_LO;
                WAIT_LO: if (byte_valid && !full) state_nxt = WAIT_HI;
                default: state_nxt = WAIT_HI;
            endcase
        end
    end

    // Handshake and dispatch outputs; byte_ready depends only on stored state
    always_comb begin
        byte_ready  = 1'b1;
        hi_pending  = 1'b0;
        instr_out   = 16'h0000;
        out_valid_0 = 1'b0;
        out_valid_1 = 1'b0;
        case (state)
            WAIT_HI: byte_ready = 1'b1;
            WAIT_LO: begin
                byte_ready = !full;
                hi_pending = 1'b1;
            end
            default: byte_ready = 1'b1;
        endcase
        if (!empty) begin
            instr_out   = head;
            out_valid_0 = !head[15];
            out_valid_1 = head[15];
        end
    end

    assign byte_acc   = byte_valid && byte_ready;
    assign push       = byte_acc && (state == WAIT_LO);
    assign pop        = (out_valid_0 && out_ready_0) || (out_valid_1 && out_ready_1);
    assign fifo_count = count;

    // High-byte holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_reg <= 8'h00;
        end else if (!flush && byte_acc && (state == WAIT_HI)) begin
            hi_reg <= byte_in;
        end
    end

    // FIFO storage; contents are only meaningful where count says so
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= {hi_reg, byte_in};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= AW'(0);
            rd_ptr <= AW'(0);
            count  <= CW'(0);
        end else if (flush) begin
            wr_ptr <= AW'(0);
            rd_ptr <= AW'(0);
            count  <= CW'(0);
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: a byte offered while not ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (byte_valid && !byte_ready) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder: expected instructions go into a scoreboard
// queue and a negedge monitor checks every dispatch handshake against it.
module tb_instr_feeder;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] instr_out;
    logic        out_valid_0;
    logic        out_ready_0;
    logic        out_valid_1;
    logic        out_ready_1;
    logic [2:0]  fifo_count;
    logic        hi_pending;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] stream [10];

    instr_feeder #(.DEPTH(4), .CW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .instr_out  (instr_out),
        .out_valid_0(out_valid_0),
        .out_ready_0(out_ready_0),
        .out_valid_1(out_valid_1),
        .out_ready_1(out_ready_1),
        .fifo_count (fifo_count),
        .hi_pending (hi_pending),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    // Sends a full instruction and records it as expected output
    task automatic send_instr(input logic [15:0] ins);
        send_byte(ins[15:8]);
        exp_q.push_back(ins);
        send_byte(ins[7:0]);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (fifo_count != 3'd0 && n < 50) begin
            tick();
            n++;
        end
        chk(name, 32'(fifo_count), 32'd0);
    endtask

    // Monitor: every accepted dispatch must match the scoreboard head and unit
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_0 && out_valid_1) chk("both_valid", 32'd1, 32'd0);
            if ((out_valid_0 && out_ready_0) || (out_valid_1 && out_ready_1)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_dispatch", 32'(instr_out), 32'hDEAD_BEEF);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    chk("dispatch_instr", 32'(instr_out), 32'(e));
                    chk("dispatch_unit", 32'(out_valid_1), 32'(e[15]));
                end
            end
        end
    end

    initial begin
        stream = '{16'h0011, 16'h8022, 16'h0033, 16'h8044, 16'h8055,
                   16'h0066, 16'h0077, 16'h8088, 16'h0099, 16'h80AA};
        rst = 1'b1; flush = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        out_ready_0 = 1'b0; out_ready_1 = 1'b0;
        tick(); tick();
        chk("rst_byte_ready", 32'(byte_ready), 32'd1);
        chk("rst_instr_out", 32'(instr_out), 32'h0);
        chk("rst_valids", 32'({out_valid_1, out_valid_0}), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_hi_pending", 32'(hi_pending), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Basic unit-0 instruction
        send_byte(8'h12);
        chk("t1_hi_pending", 32'(hi_pending), 32'd1);
        exp_q.push_back(16'h1234);
        send_byte(8'h34);
        chk("t1_instr", 32'(instr_out), 32'h1234);
        chk("t1_valids", 32'({out_valid_1, out_valid_0}), 32'b01);
        chk("t1_count", 32'(fifo_count), 32'd1);
        out_ready_0 = 1'b1;
        tick();
        out_ready_0 = 1'b0;
        chk("t1_count_after", 32'(fifo_count), 32'd0);
        chk("t1_valid0_after", 32'(out_valid_0), 32'd0);

        // Unit-1 instruction with ready already high: valid for one cycle
        out_ready_1 = 1'b1;
        send_instr(16'h9ABC);
        chk("t2_instr", 32'(instr_out), 32'h9ABC);
        chk("t2_valids", 32'({out_valid_1, out_valid_0}), 32'b10);
        tick();
        chk("t2_valids_after", 32'({out_valid_1, out_valid_0}), 32'b00);
        out_ready_1 = 1'b0;

        // Fill, overflow, pop, wrap
        send_instr(16'h0101);
        send_instr(16'h8202);
        send_instr(16'h0303);
        send_instr(16'h8404);
        chk("t3_full", 32'(fifo_count), 32'd4);
        send_byte(8'h05);
        chk("t3_hi_pending", 32'(hi_pending), 32'd1);
        chk("t3_byte_ready", 32'(byte_ready), 32'd0);
        send_byte(8'h06);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_count_held", 32'(fifo_count), 32'd4);
        chk("t3_still_pending", 32'(hi_pending), 32'd1);
        out_ready_0 = 1'b1;
        tick();
        out_ready_0 = 1'b0;
        chk("t3_ready_back", 32'(byte_ready), 32'd1);
        chk("t3_count3", 32'(fifo_count), 32'd3);
        exp_q.push_back(16'h0506);
        send_byte(8'h06);
        chk("t3_count4", 32'(fifo_count), 32'd4);
        chk("t3_head", 32'(instr_out), 32'h8202);
        out_ready_0 = 1'b1; out_ready_1 = 1'b1;
        wait_drain("t3_drain");
        out_ready_0 = 1'b0; out_ready_1 = 1'b0;
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);

        // Head-of-line blocking
        out_ready_1 = 1'b1;
        send_instr(16'h0001);
        send_instr(16'h8002);
        tick(); tick();
        chk("t4_blocked", 32'(fifo_count), 32'd2);
        chk("t4_head", 32'(instr_out), 32'h0001);
        out_ready_0 = 1'b1;
        tick();
        chk("t4_count1", 32'(fifo_count), 32'd1);
        chk("t4_head2", 32'(instr_out), 32'h8002);
        tick();
        chk("t4_count0", 32'(fifo_count), 32'd0);

        // Steady stream: one push every two cycles, both units always ready
        for (int i = 0; i < 10; i++) begin
            send_instr(stream[i]);
            chk("t5_count", 32'(fifo_count), 32'd1);
        end
        wait_drain("t5_drain");
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        out_ready_0 = 1'b0; out_ready_1 = 1'b0;

        // Asynchronous reset mid-transfer
        send_instr(16'h4321);
        send_byte(8'h77);
        chk("t6_pre_pending", 32'(hi_pending), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_arst_count", 32'(fifo_count), 32'd0);
        chk("t6_arst_pending", 32'(hi_pending), 32'd0);
        chk("t6_arst_instr", 32'(instr_out), 32'h0);
        chk("t6_arst_overflow", 32'(overflow), 32'd0);
        chk("t6_arst_byte_ready", 32'(byte_ready), 32'd1);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();

        // Flush while overflow is set, with a push and a pop in the same cycle
        send_instr(16'h0101);
        send_instr(16'h0202);
        send_instr(16'h0303);
        send_instr(16'h0404);
        send_byte(8'h05);
        send_byte(8'h06);
        chk("t7_overflow", 32'(overflow), 32'd1);
        out_ready_0 = 1'b1;
        tick();
        out_ready_0 = 1'b0;
        chk("t7_count3", 32'(fifo_count), 32'd3);
        flush = 1'b1; byte_valid = 1'b1; byte_in = 8'h06; out_ready_0 = 1'b1;
        tick();
        flush = 1'b0; byte_valid = 1'b0; out_ready_0 = 1'b0;
        exp_q.delete();
        chk("t7_flush_count", 32'(fifo_count), 32'd0);
        chk("t7_flush_overflow", 32'(overflow), 32'd0);
        chk("t7_flush_pending", 32'(hi_pending), 32'd0);
        chk("t7_flush_instr", 32'(instr_out), 32'h0);
        chk("t7_flush_valids", 32'({out_valid_1, out_valid_0}), 32'd0);

        // Pointers restart cleanly after flush
        out_ready_1 = 1'b1;
        send_instr(16'hF00D);
        chk("t7_post_instr", 32'(instr_out), 32'hF00D);
        tick();
        chk("t7_post_count", 32'(fifo_count), 32'd0);
        chk("t7_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
